// File: rtl/blink_pkg.sv
// Shared types for the blink generator: LED channel modes and per-channel FSM states.
package blink_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2,
        BURST = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/blink_gen_if.sv
// Configuration-write and LED status bundle between a controller and blink_gen.
interface blink_gen_if
    import blink_pkg::*;
#(
    parameter int NB_CH   = 4,
    parameter int CPT_W   = 26,
    parameter int BURST_W = 8
);
    localparam int CH_W = (NB_CH > 1) ? $clog2(NB_CH) : 1;

    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    mode_e              cfg_mode;
    logic [CPT_W-1:0]   cfg_half;
    logic [BURST_W-1:0] cfg_burst;
    logic [NB_CH-1:0]   led_o;
    logic [NB_CH-1:0]   tick_o;
    logic [NB_CH-1:0]   done_o;
    logic [NB_CH-1:0]   busy_o;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst,
        input  led_o, tick_o, done_o, busy_o
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_burst,
        output led_o, tick_o, done_o, busy_o
    );

endinterface

// File: rtl/blink_ch.sv
// One LED channel: half-period counter, burst toggle count, IDLE/RUN FSM, registered outputs.
module blink_ch
    import blink_pkg::*;
#(
    parameter int CPT_W    = 26,
    parameter int DEF_HALF = 25_000_000,
    parameter int BURST_W  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_we,
    input  mode_e              i_mode,
    input  logic [CPT_W-1:0]   i_half,
    input  logic [BURST_W-1:0] i_burst,
    output logic               o_led,
    output logic               o_tick,
    output logic               o_done,
    output logic               o_busy
);
    localparam int TOG_W = BURST_W + 1;

    state_e             r_state, w_state_nxt;
    mode_e              r_mode,  w_mode_nxt;
    logic [CPT_W-1:0]   r_half,  w_half_nxt;
    logic [BURST_W-1:0] r_burst, w_burst_nxt;
    logic [CPT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [TOG_W-1:0]   r_tog,   w_tog_nxt;
    logic               r_led,   w_led_nxt;
    logic               r_tick,  w_tick_nxt;
    logic               r_done,  w_done_nxt;

    logic               w_term;
    logic [TOG_W-1:0]   w_tog_inc;
    logic [TOG_W-1:0]   w_tog_target;

    assign w_term       = (r_cnt == r_half - CPT_W'(1));
    assign w_tog_inc    = r_tog + TOG_W'(1);
    assign w_tog_target = {r_burst, 1'b0};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_half_nxt  = r_half;
        w_burst_nxt = r_burst;
        w_cnt_nxt   = r_cnt;
        w_tog_nxt   = r_tog;
        w_led_nxt   = r_led;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        // A write always wins over a terminal count or burst completion in the same cycle.
        if (i_we) begin
            w_mode_nxt  = i_mode;
            w_half_nxt  = (i_half == '0) ? CPT_W'(1) : i_half;
            w_burst_nxt = i_burst;
            w_cnt_nxt   = '0;
            w_tog_nxt   = '0;
            case (i_mode)
                OFF: begin
                    w_led_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
                ON: begin
                    w_led_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_led_nxt   = 1'b0;
                    w_state_nxt = RUN;
                end
            endcase
        end else if (r_state == RUN) begin
            if (r_mode == BURST && r_burst == '0) begin
                w_done_nxt  = 1'b1;
                w_mode_nxt  = OFF;
                w_state_nxt = IDLE;
            end else if (w_term) begin
                w_cnt_nxt  = '0;
                w_led_nxt  = ~r_led;
                w_tick_nxt = 1'b1;
                if (r_mode == BURST) begin
                    w_tog_nxt = w_tog_inc;
                    if (w_tog_inc == w_tog_target) begin
                        w_done_nxt  = 1'b1;
                        w_mode_nxt  = OFF;
                        w_state_nxt = IDLE;
                    end
                end
            end else begin
                w_cnt_nxt = r_cnt + CPT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_mode  <= OFF;
            r_half  <= CPT_W'(DEF_HALF);
            r_burst <= '0;
            r_cnt   <= '0;
            r_tog   <= '0;
            r_led   <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values from always_comb.
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_half  <= w_half_nxt;
            r_burst <= w_burst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tog   <= w_tog_nxt;
            r_led   <= w_led_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_led  = r_led;
    assign o_tick = r_tick;
    assign o_done = r_done;
    assign o_busy = (r_state == RUN);

endmodule

// File: rtl/blink_gen.sv
// Multi-channel LED blink generator: decodes configuration writes onto NB_CH blink_ch instances.
module blink_gen
    import blink_pkg::*;
#(
    parameter int NB_CH    = 4,
    parameter int CPT_W    = 26,
    parameter int DEF_HALF = 25_000_000,
    parameter int BURST_W  = 8
) (
    input  logic       CLK,
    input  logic       RST,
    blink_gen_if.slave bus
);
    logic [NB_CH-1:0] w_we;
    logic [NB_CH-1:0] w_led;
    logic [NB_CH-1:0] w_tick;
    logic [NB_CH-1:0] w_done;
    logic [NB_CH-1:0] w_busy;

    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        // Only existing channel indices can match, so out-of-range writes fall through.
        assign w_we[i] = bus.cfg_we && (32'(bus.cfg_ch) == i);

        blink_ch #(
            .CPT_W    (CPT_W),
            .DEF_HALF (DEF_HALF),
            .BURST_W  (BURST_W)
        ) u_ch (
            .CLK     (CLK),
            .RST     (RST),
            .i_we    (w_we[i]),
            .i_mode  (bus.cfg_mode),
            .i_half  (bus.cfg_half),
            .i_burst (bus.cfg_burst),
            .o_led   (w_led[i]),
            .o_tick  (w_tick[i]),
            .o_done  (w_done[i]),
            .o_busy  (w_busy[i])
        );
    end

    assign bus.led_o  = w_led;
    assign bus.tick_o = w_tick;
    assign bus.done_o = w_done;
    assign bus.busy_o = w_busy;

endmodule

// File: tb/tb_blink_gen.sv
// Self-checking bench for blink_gen: per-cycle behavioural model plus directed literal checks.
module tb_blink_gen;
    import blink_pkg::*;

    localparam int NB  = 4;
    localparam int CW  = 8;
    localparam int BW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blink_gen_if #(.NB_CH(NB), .CPT_W(CW), .BURST_W(BW)) bus ();
    blink_gen #(.NB_CH(NB), .CPT_W(CW), .DEF_HALF(5), .BURST_W(BW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Three-channel instance so that an out-of-range channel index is representable.
    blink_gen_if #(.NB_CH(3), .CPT_W(CW), .BURST_W(BW)) bus3 ();
    blink_gen #(.NB_CH(3), .CPT_W(CW), .DEF_HALF(5), .BURST_W(BW)) dut3 (
        .CLK (clk),
        .RST (rst),
        .bus (bus3)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    mode_e m_mode [NB];
    int    m_w    [NB];
    int    m_h    [NB];
    int    m_b    [NB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Expected {led, tick, done, busy} from the channel's last write, by elapsed cycles.
    function automatic logic [3:0] model_out(int ch);
        int n, h, t;
        logic led, tick, done, busy;
        n = cyc - m_w[ch];
        h = m_h[ch];
        led = 0; tick = 0; done = 0; busy = 0;
        case (m_mode[ch])
            ON:    led = 1;
            BLINK: begin
                busy = 1;
                if (n > 0) begin
                    tick = (n % h == 0);
                    led  = ((n / h) % 2) == 1;
                end
            end
            BURST: begin
                if (m_b[ch] == 0) begin
                    busy = (n == 0);
                    done = (n == 1);
                end else begin
                    t = 2 * m_b[ch] * h;
                    if (n < t) begin
                        busy = 1;
                        if (n > 0) begin
                            tick = (n % h == 0);
                            led  = ((n / h) % 2) == 1;
                        end
                    end else if (n == t) begin
                        tick = 1;
                        done = 1;
                    end
                end
            end
            default: ;
        endcase
        return {led, tick, done, busy};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int ch = 0; ch < NB; ch++) begin
                check($sformatf("cyc%0d_ch%0d_ltdb", cyc, ch),
                      {28'd0, bus.led_o[ch], bus.tick_o[ch], bus.done_o[ch], bus.busy_o[ch]},
                      {28'd0, model_out(ch)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic write(input int ch, input mode_e mode, input int half, input int burst);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_mode  = mode;
        bus.cfg_half  = CW'(half);
        bus.cfg_burst = BW'(burst);
        step();
        bus.cfg_we = 1'b0;
        m_mode[ch] = mode;
        m_w[ch]    = cyc;
        m_h[ch]    = (half == 0) ? 1 : half;
        m_b[ch]    = burst;
    endtask

    task automatic write3(input int ch, input mode_e mode, input int half);
        bus3.cfg_we    = 1'b1;
        bus3.cfg_ch    = 2'(ch);
        bus3.cfg_mode  = mode;
        bus3.cfg_half  = CW'(half);
        bus3.cfg_burst = '0;
        step();
        bus3.cfg_we = 1'b0;
    endtask

    initial begin
        int w, n, ticks, dones;
        for (int ch = 0; ch < NB; ch++) begin
            m_mode[ch] = OFF; m_w[ch] = 0; m_h[ch] = 5; m_b[ch] = 0;
        end
        bus.cfg_we = 0;  bus.cfg_ch = '0;  bus.cfg_mode = OFF;  bus.cfg_half = '0;  bus.cfg_burst = '0;
        bus3.cfg_we = 0; bus3.cfg_ch = '0; bus3.cfg_mode = OFF; bus3.cfg_half = '0; bus3.cfg_burst = '0;

        step(); step(); step();
        check("reset_outputs", {bus.led_o, bus.tick_o, bus.done_o, bus.busy_o}, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // ch0 BLINK half=3: rises at 3, falls at 6, ticks at 3/6/9.
        write(0, BLINK, 3, 0);
        w = cyc;
        check("ch0_busy_after_write", bus.busy_o[0], 1);
        check("ch0_led_after_write", bus.led_o[0], 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            n = cyc - w;
            if (n == 2) check("ch0_led_c2", bus.led_o[0], 0);
            if (n == 3) check("ch0_rise_c3", {bus.led_o[0], bus.tick_o[0]}, 2'b11);
            if (n == 4) check("ch0_tick_c4", bus.tick_o[0], 0);
            if (n == 6) check("ch0_fall_c6", {bus.led_o[0], bus.tick_o[0]}, 2'b01);
            if (n == 9) check("ch0_tick_c9", bus.tick_o[0], 1);
        end

        // ch1 BURST half=2 burst=3: six ticks, done with the sixth at cycle 12.
        write(1, BURST, 2, 3);
        w = cyc; ticks = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            n = cyc - w;
            ticks += int'(bus.tick_o[1]);
            if (n == 11) check("ch1_done_c11", bus.done_o[1], 0);
            if (n == 12) check("ch1_done_c12", {bus.tick_o[1], bus.done_o[1], bus.led_o[1]}, 3'b110);
        end
        check("ch1_tick_count", ticks, 6);
        check("ch1_idle_after_burst", {bus.led_o[1], bus.busy_o[1]}, 2'b00);

        // ch2 BURST burst=0: done next cycle, no tick. ch3 half=0 toggles every cycle.
        write(2, BURST, 3, 0);
        step();
        check("ch2_done_next", {bus.done_o[2], bus.tick_o[2], bus.busy_o[2]}, 3'b100);
        step();
        check("ch2_done_single", bus.done_o[2], 0);
        write(3, BLINK, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("ch3_toggle_%0d", k), {bus.led_o[3], bus.tick_o[3]}, {k[0], 1'b1});
        end

        // Rewrite ch0 ON on the edge where its half=4 counter reaches terminal.
        write(0, BLINK, 4, 0);
        step(); step(); step();
        write(0, ON, 4, 0);
        check("ch0_on_precedence", {bus.led_o[0], bus.tick_o[0], bus.busy_o[0]}, 3'b100);
        check("ch3_still_running", bus.busy_o[3], 1);
        step();
        check("ch0_on_holds", bus.led_o[0], 1);

        // Async reset in the middle of a ch1 burst.
        write(1, BURST, 2, 3);
        for (int k = 0; k < 5; k++) step();
        #2;
        rst = 1'b1;
        for (int ch = 0; ch < NB; ch++) m_mode[ch] = OFF;
        #1;
        check("async_reset_outputs", {bus.led_o, bus.tick_o, bus.done_o, bus.busy_o}, 0);
        step();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            dones += int'(bus.done_o[1]);
        end
        check("no_done_after_reset", dones, 0);
        check("idle_after_reset", {bus.led_o, bus.busy_o}, 0);

        // Out-of-range channel on the three-channel instance, then a valid one.
        write3(3, BLINK, 1);
        check("oob_ignored_busy", bus3.busy_o, 0);
        step();
        check("oob_ignored_led", bus3.led_o, 0);
        write3(2, BLINK, 1);
        check("ch2_of_3_busy", bus3.busy_o, 3'b100);
        step();
        check("ch2_of_3_led", bus3.led_o, 3'b100);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
